instr_fetch: RTL and testbench

- Fetch stage directly upstream of the control decoder.
- Owns the program counter and drives a synchronous instruction ROM (1-cycle read latency).
- Presents one 9-bit machine-code word per cycle with a valid flag, and applies branch/jump redirects from the execute side.
- Runs a program on a start pulse and raises done on a halt instruction.

---
 rtl/instr_fetch.sv | 129 ++++++++++++
 tb/tb_instr_fetch.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, drives a 1-cycle synchronous ROM and applies redirects.
// Optional run-cycle counter enabled by INSTR_FETCH_CYCCNT_EN.
module instr_fetch #(
  parameter int PCW = 10,
  parameter int IW = 9,
  parameter int OFFW = 6,
  parameter logic [IW-1:0] HALT_CODE = 9'h1FF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [PCW-1:0]  start_addr,
  output logic            done,
  output logic [PCW-1:0]  instr_addr,
  input  logic [IW-1:0]   instr_data,
  output logic [IW-1:0]   instr,
  output logic [PCW-1:0]  instr_pc,
  output logic            instr_valid,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [OFFW-1:0] branch_offset,
  input  logic            jump,
  input  logic [PCW-1:0]  jump_target,
  output logic [15:0]     cycle_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRIME,
    S_RUN,
    S_DONE
  } state_t;

  state_t         state, state_nxt;
  logic [PCW-1:0] pc, pc_nxt;
  logic [PCW-1:0] issue_pc, issue_nxt;
  logic           squash, squash_nxt;
  logic           done_nxt;
  logic           valid, advance, halt, redirect;
  logic [PCW-1:0] off_ext, target;

  assign valid    = (state == S_RUN) && !squash;
  assign advance  = valid && !stall;
  assign halt     = advance && (instr_data == HALT_CODE);
  assign redirect = advance && !halt && (jump || branch_taken);
  assign off_ext  = {{(PCW-OFFW){branch_offset[OFFW-1]}}, branch_offset};
  assign target   = jump ? jump_target : issue_pc + off_ext;

  assign instr_valid = valid;
  assign instr       = valid ? instr_data : '0;
  assign instr_pc    = issue_pc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      pc       <= '0;
      issue_pc <= '0;
      squash   <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      issue_pc <= issue_nxt;
      squash   <= squash_nxt;
      done     <= done_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    issue_nxt  = issue_pc;
    squash_nxt = squash;
    done_nxt   = done;
    instr_addr = pc;
    unique case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          pc_nxt    = start_addr;
          done_nxt  = 1'b0;
          state_nxt = S_PRIME;
        end
      end
      S_PRIME: begin
        pc_nxt     = pc + PCW'(1);
        issue_nxt  = pc;
        squash_nxt = 1'b0;
        state_nxt  = S_RUN;
      end
      S_RUN: begin
        if (squash) begin
          pc_nxt     = pc + PCW'(1);
          issue_nxt  = pc;
          squash_nxt = 1'b0;
        end else if (stall) begin
          // re-read the held address so instr stays stable
          instr_addr = issue_pc;
        end else if (halt) begin
          state_nxt = S_DONE;
          done_nxt  = 1'b1;
        end else if (redirect) begin
          pc_nxt     = target;
          squash_nxt = 1'b1;
        end else begin
          pc_nxt    = pc + PCW'(1);
          issue_nxt = pc;
        end
      end
      default: ;
    endcase
  end

`ifdef INSTR_FETCH_CYCCNT_EN
  logic [15:0] cnt;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if ((state == S_IDLE || state == S_DONE) && start) begin
      cnt <= '0;
    end else if ((state == S_PRIME || state == S_RUN) && cnt != 16'hFFFF) begin
      cnt <= cnt + 16'd1;
    end
  end
  assign cycle_count = cnt;
`else
  assign cycle_count = '0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a behavioural 1-cycle ROM.
// Expected values are hand-computed per step.
module tb_instr_fetch;

  logic       clk;
  logic       reset;
  logic       start;
  logic [9:0] start_addr;
  logic       done;
  logic [9:0] instr_addr;
  logic [8:0] instr_data;
  logic [8:0] instr;
  logic [9:0] instr_pc;
  logic       instr_valid;
  logic       stall;
  logic       branch_taken;
  logic [5:0] branch_offset;
  logic       jump;
  logic [9:0] jump_target;
  logic [15:0] cycle_count;

  logic [8:0] rom [0:1023];
  int compared = 0;
  int mismatched = 0;
  int exp_cc;

  instr_fetch dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .start_addr(start_addr),
    .done(done),
    .instr_addr(instr_addr),
    .instr_data(instr_data),
    .instr(instr),
    .instr_pc(instr_pc),
    .instr_valid(instr_valid),
    .stall(stall),
    .branch_taken(branch_taken),
    .branch_offset(branch_offset),
    .jump(jump),
    .jump_target(jump_target),
    .cycle_count(cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) instr_data <= rom[instr_addr];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      logic [9:0] a;
      a = i[9:0];
      rom[i] = (a[8:0] == 9'h1FF) ? 9'h000 : a[8:0];
    end
    rom[10'h014] = 9'h1FF;
`ifdef INSTR_FETCH_CYCCNT_EN
    exp_cc = 6;
`else
    exp_cc = 0;
`endif
    reset = 1'b1;
    start = 1'b0;
    start_addr = '0;
    stall = 1'b0;
    branch_taken = 1'b0;
    branch_offset = '0;
    jump = 1'b0;
    jump_target = '0;

    tick(); tick();
    chk("rst_valid", instr_valid, 0);
    chk("rst_instr", instr, 0);
    chk("rst_pc", instr_pc, 0);
    chk("rst_addr", instr_addr, 0);
    chk("rst_done", done, 0);
    chk("rst_cc", cycle_count, 0);
    reset = 1'b0;

    // sequential fetch from 0x010
    tick(); start = 1; start_addr = 10'h010; #1;
    chk("idle_valid", instr_valid, 0);
    tick(); start = 0; #1;
    chk("prime_valid", instr_valid, 0);
    chk("prime_addr", instr_addr, 10'h010);
    tick();
    chk("seq0_valid", instr_valid, 1);
    chk("seq0_pc", instr_pc, 10'h010);
    chk("seq0_instr", instr, 9'h010);
    tick(); start = 1; start_addr = 10'h200; #1;
    chk("seq1_pc", instr_pc, 10'h011);
    chk("seq1_instr", instr, 9'h011);

    // branch -2 at 0x012; start in RUN is ignored
    tick(); start = 0; branch_taken = 1; branch_offset = 6'h3E; #1;
    chk("seq2_pc", instr_pc, 10'h012);
    chk("seq2_valid", instr_valid, 1);
    tick(); branch_taken = 0; #1;
    chk("br_bubble", instr_valid, 0);
    chk("br_bub_instr", instr, 0);
    chk("br_bub_addr", instr_addr, 10'h010);
    tick();
    chk("br_tgt_pc", instr_pc, 10'h010);
    chk("br_tgt_instr", instr, 9'h010);
    tick();
    chk("br_next_pc", instr_pc, 10'h011);

    // jump beats branch
    tick(); jump = 1; jump_target = 10'h100; branch_taken = 1; #1;
    chk("pri_src_pc", instr_pc, 10'h012);
    tick(); jump = 0; branch_taken = 0; #1;
    chk("pri_bubble", instr_valid, 0);
    tick(); jump = 1; jump_target = 10'h3FF; #1;
    chk("pri_pc", instr_pc, 10'h100);
    chk("pri_instr", instr, 9'h100);

    // wrap-around
    tick(); jump = 0; #1;
    chk("wrap_bubble", instr_valid, 0);
    tick();
    chk("wrap_top_pc", instr_pc, 10'h3FF);
    chk("wrap_top_valid", instr_valid, 1);
    tick(); jump = 1; jump_target = 10'h010; #1;
    chk("wrap_zero_pc", instr_pc, 10'h000);
    chk("wrap_zero_valid", instr_valid, 1);
    tick(); jump = 0; #1;
    chk("j10_bubble", instr_valid, 0);
    tick();
    chk("j10_pc", instr_pc, 10'h010);

    // stall 3 cycles at 0x011 with branch asserted
    tick(); stall = 1; branch_taken = 1; branch_offset = 6'h05; #1;
    chk("stl0_pc", instr_pc, 10'h011);
    chk("stl0_addr", instr_addr, 10'h011);
    tick();
    chk("stl1_pc", instr_pc, 10'h011);
    chk("stl1_instr", instr, 9'h011);
    tick();
    chk("stl2_instr", instr, 9'h011);
    tick(); stall = 0; branch_taken = 0; #1;
    chk("stl3_pc", instr_pc, 10'h011);
    chk("stl3_instr", instr, 9'h011);
    chk("stl3_valid", instr_valid, 1);
    tick();
    chk("stl_rel_pc", instr_pc, 10'h012);
    tick();
    chk("seq13_pc", instr_pc, 10'h013);
    tick();
    chk("halt_pc", instr_pc, 10'h014);
    chk("halt_instr", instr, 9'h1FF);
    chk("halt_done0", done, 0);
    tick();
    chk("halt_done", done, 1);
    chk("halt_valid", instr_valid, 0);
    tick();
    chk("done_hold", done, 1);

    // restart at 0x010 and run to halt for cycle count
    tick(); start = 1; start_addr = 10'h010; #1;
    tick(); start = 0; #1;
    chk("rs_done_clr", done, 0);
    tick();
    chk("rs_pc0", instr_pc, 10'h010);
    tick(); tick(); tick(); tick();
    chk("rs_halt_pc", instr_pc, 10'h014);
    tick();
    chk("rs_done", done, 1);
    chk("rs_valid", instr_valid, 0);
    chk("rs_cc", cycle_count, exp_cc);
    tick();
    chk("rs_cc_hold", cycle_count, exp_cc);

    // restart at 0x000
    tick(); start = 1; start_addr = 10'h000; #1;
    tick(); start = 0; #1;
    chk("r0_done_clr", done, 0);
    tick();
    chk("r0_pc", instr_pc, 10'h000);
    chk("r0_valid", instr_valid, 1);
    tick(); jump = 1; jump_target = 10'h012; #1;
    chk("r0_pc1", instr_pc, 10'h001);
    tick(); jump = 0; #1;
    tick();
    chk("ar_pre_pc", instr_pc, 10'h012);

    // async reset mid-run
    reset = 1; #1;
    chk("ar_valid", instr_valid, 0);
    chk("ar_done", done, 0);
    chk("ar_addr", instr_addr, 0);
    chk("ar_instr", instr, 0);
    tick(); tick(); reset = 0;
    tick(); tick();
    chk("ar_idle_valid", instr_valid, 0);
    chk("ar_idle_addr", instr_addr, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
